// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer: FSM states, deck geometry
// and the index-to-blackjack-value mapping.
package dealer_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANKS     = 13;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned LEFT_W    = 6;
    localparam int unsigned VAL_W     = 4;
    localparam int unsigned LFSR_W    = 16;

    localparam logic [VAL_W-1:0]  ACE_VALUE  = 4'd11;
    localparam logic [VAL_W-1:0]  FACE_VALUE = 4'd10;
    localparam logic [LFSR_W-1:0] LFSR_MASK  = 16'hB400;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        PROBE = 3'd2,
        DEAL  = 3'd3,
        EMPTY = 3'd4
    } state_t;

    // rank 0 is the ace, ranks 10..12 are the face cards
    function automatic logic [VAL_W-1:0] card_value(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] rank;
        rank = idx % IDX_W'(RANKS);
        if (rank == '0)
            card_value = ACE_VALUE;
        else if (rank <= IDX_W'(9))
            card_value = VAL_W'(rank + IDX_W'(1));
        else
            card_value = FACE_VALUE;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/deal bus between the game FSM (master) and the card dealer (slave).
// card_id exists only when CARD_ID_EN is defined.
interface card_dealer_if;
    import dealer_pkg::*;

    logic                get_card;
    logic                card_rdy;
    logic [VAL_W-1:0]    card_out;
    logic [LEFT_W-1:0]   cards_left;
    logic                deck_empty;
`ifdef CARD_ID_EN
    logic [IDX_W-1:0]    card_id;

    modport master (output get_card, input card_rdy, input card_out,
                    input cards_left, input deck_empty, input card_id);
    modport slave  (input get_card, output card_rdy, output card_out,
                    output cards_left, output deck_empty, output card_id);
`else
    modport master (output get_card, input card_rdy, input card_out,
                    input cards_left, input deck_empty);
    modport slave  (input get_card, output card_rdy, output card_out,
                    output cards_left, output deck_empty);
`endif

endinterface

// File: rtl/card_dealer_lfsr16.sv
// 16-bit Galois LFSR used to shuffle the deck; a zero load value is replaced
// by SEED_INIT so the register can never lock up.
module lfsr16
    import dealer_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_INIT = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= SEED_INIT;
        else if (load)
            q <= (load_val == '0) ? SEED_INIT : load_val;
        else
            q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    end

endmodule

// File: rtl/card_dealer.sv
// Single-deck card source: deals cards without replacement, positions chosen by
// an LFSR seeded from button timing. Optional card_id output under CARD_ID_EN.
module card_dealer
    import dealer_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_INIT = 16'hACE1,
    parameter int unsigned       DECK_SIZE = 52
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          loadseed_i,
    input  logic          shuffle_i,
    card_dealer_if.slave  bus
);

    state_t                 state, state_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [DECK_SIZE-1:0]   drawn, drawn_n;
    logic [LEFT_W-1:0]      cards_left, cards_left_n;
    logic [VAL_W-1:0]       card_out, card_out_n;
    logic                   card_rdy, card_rdy_n;
    logic                   deck_empty, deck_empty_n;
    logic [LFSR_W-1:0]      seed_cnt;
    logic [LFSR_W-1:0]      lfsr_q;
    logic [IDX_W-1:0]       pick_idx_c;
    logic                   unused_lfsr_hi;
`ifdef CARD_ID_EN
    logic [IDX_W-1:0]       card_id, card_id_n;
`endif

    // Free-running entropy counter; only reset clears it
    always_ff @(posedge clk) begin
        if (reset)
            seed_cnt <= '0;
        else
            seed_cnt <= seed_cnt + LFSR_W'(1);
    end

    lfsr16 #(.SEED_INIT(SEED_INIT)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (loadseed_i),
        .load_val (seed_cnt),
        .q        (lfsr_q)
    );

    // Fold 52..63 back onto 0..11 so every raw value hits a real slot
    assign pick_idx_c = (lfsr_q[IDX_W-1:0] >= IDX_W'(DECK_SIZE))
                      ? lfsr_q[IDX_W-1:0] - IDX_W'(DECK_SIZE)
                      : lfsr_q[IDX_W-1:0];
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:IDX_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            drawn      <= '0;
            cards_left <= LEFT_W'(DECK_SIZE);
            card_out   <= '0;
            card_rdy   <= 1'b0;
            deck_empty <= 1'b0;
`ifdef CARD_ID_EN
            card_id    <= '0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            drawn      <= drawn_n;
            cards_left <= cards_left_n;
            card_out   <= card_out_n;
            card_rdy   <= card_rdy_n;
            deck_empty <= deck_empty_n;
`ifdef CARD_ID_EN
            card_id    <= card_id_n;
`endif
        end
    end

    // Deal outputs are loaded on the PROBE->DEAL edge so they are visible
    // during the DEAL cycle itself; shuffle overrides everything.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        drawn_n      = drawn;
        cards_left_n = cards_left;
        card_out_n   = card_out;
        card_rdy_n   = 1'b0;
`ifdef CARD_ID_EN
        card_id_n    = card_id;
`endif
        if (shuffle_i) begin
            state_n      = IDLE;
            drawn_n      = '0;
            cards_left_n = LEFT_W'(DECK_SIZE);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.get_card)
                        state_n = (cards_left != '0) ? PICK : EMPTY;
                end
                PICK: begin
                    idx_n   = pick_idx_c;
                    state_n = PROBE;
                end
                PROBE: begin
                    if (drawn[idx]) begin
                        idx_n = (idx == IDX_W'(DECK_SIZE - 1)) ? '0 : idx + IDX_W'(1);
                    end else begin
                        state_n      = DEAL;
                        drawn_n[idx] = 1'b1;
                        cards_left_n = cards_left - LEFT_W'(1);
                        card_out_n   = card_value(idx);
                        card_rdy_n   = 1'b1;
`ifdef CARD_ID_EN
                        card_id_n    = idx;
`endif
                    end
                end
                DEAL: begin
                    if (bus.get_card)
                        state_n = (cards_left != '0) ? PICK : EMPTY;
                    else
                        state_n = IDLE;
                end
                EMPTY: state_n = EMPTY;
                default: state_n = IDLE;
            endcase
        end
        deck_empty_n = (cards_left_n == '0);
    end

    assign bus.card_rdy   = card_rdy;
    assign bus.card_out   = card_out;
    assign bus.cards_left = cards_left;
    assign bus.deck_empty = deck_empty;
`ifdef CARD_ID_EN
    assign bus.card_id    = card_id;
`endif

endmodule
